// File: rtl/axi4lite_pkg.sv
// Constants shared by the AXI4-Lite master and slave endpoints.
package axi4lite_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// NREGS x 32 register bank: one byte-strobed write port, one combinational
// read port, flattened contents and a registered per-register write pulse.
module axi4lite_regfile
    import axi4lite_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IDX_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [STRB_WIDTH-1:0]       wr_strb,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [NREGS*DATA_WIDTH-1:0] reg_q,
    output logic [NREGS-1:0]            wr_pulse
);

    logic [NREGS-1:0] wr_sel;
    logic [NREGS-1:0] wr_pulse_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] q_reg;

            assign wr_sel[gi] = we && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (wr_sel[gi]) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wr_strb[b]) begin
                            q_reg[8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_q[DATA_WIDTH*gi +: DATA_WIDTH] = q_reg;
        end
    endgenerate

    // Pulse fires even for an all-zero strobe: the access itself is the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= wr_sel;
        end
    end

    assign wr_pulse = wr_pulse_reg;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = reg_q[DATA_WIDTH*k +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave terminating all five channels onto an NREGS x 32 register
// bank; AW and W are buffered independently and committed together.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NREGS      = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [ADDR_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        WVALID,
    output logic                        WREADY,
    input  logic [DATA_WIDTH-1:0]       WDATA,
    input  logic [STRB_WIDTH-1:0]       WSTRB,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [1:0]                  BRESP,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [ADDR_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [DATA_WIDTH-1:0]       RDATA,
    output logic [1:0]                  RRESP,
    output logic [NREGS*DATA_WIDTH-1:0] reg_q,
    output logic [NREGS-1:0]            wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    logic                  aw_full_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic                  w_full_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic                  commit;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_bits;

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign ar_idx      = ARADDR[ADDR_WIDTH-1:2];
    assign aw_in_range = 32'(aw_idx_reg) < 32'(NREGS);
    assign ar_in_range = 32'(ar_idx) < 32'(NREGS);

    // A pending response blocks the next commit unless it is consumed this edge.
    assign commit = aw_full_reg && w_full_reg && (!bvalid_reg || BREADY);
    assign ar_hs  = ARVALID && !rvalid_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_full_reg <= 1'b0;
            end else if (AWVALID && !aw_full_reg) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= AWADDR[ADDR_WIDTH-1:2];
            end

            if (commit) begin
                w_full_reg <= 1'b0;
            end else if (WVALID && !w_full_reg) begin
                w_full_reg <= 1'b1;
                w_data_reg <= WDATA;
                w_strb_reg <= WSTRB;
            end

            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= resp_for(aw_in_range);
            end else if (BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= ar_in_range ? rd_data : '0;
            rresp_reg  <= resp_for(ar_in_range);
        end else if (RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    axi4lite_regfile #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk      (ACLK),
        .rst      (ARESET),
        .we       (commit && aw_in_range),
        .wr_idx   (aw_idx_reg),
        .wr_data  (w_data_reg),
        .wr_strb  (w_strb_reg),
        .rd_idx   (ar_idx),
        .rd_data  (rd_data),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    assign AWREADY = !aw_full_reg;
    assign WREADY  = !w_full_reg;
    assign BVALID  = bvalid_reg;
    assign BRESP   = bresp_reg;
    assign ARREADY = !rvalid_reg;
    assign RVALID  = rvalid_reg;
    assign RDATA   = rdata_reg;
    assign RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_axi4lite_slave_regs;

    localparam int ADDR_WIDTH = 12;
    localparam int NREGS      = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  awvalid, awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid, wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic                  arvalid, arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid, rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic [NREGS*32-1:0]   reg_q;
    logic [NREGS-1:0]      wr_pulse;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    axi4lite_slave_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREGS      (NREGS)
    ) dut (
        .ACLK     (clk),
        .ARESET   (rst),
        .AWVALID  (awvalid),
        .AWREADY  (awready),
        .AWADDR   (awaddr),
        .AWPROT   (awprot),
        .WVALID   (wvalid),
        .WREADY   (wready),
        .WDATA    (wdata),
        .WSTRB    (wstrb),
        .BVALID   (bvalid),
        .BREADY   (bready),
        .BRESP    (bresp),
        .ARVALID  (arvalid),
        .ARREADY  (arready),
        .ARADDR   (araddr),
        .ARPROT   (arprot),
        .RVALID   (rvalid),
        .RREADY   (rready),
        .RDATA    (rdata),
        .RRESP    (rresp),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] regv(input int k);
        return reg_q[32*k +: 32];
    endfunction

    // AW and W in the same cycle; commit one edge later, response consumed after.
    task automatic write_same(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("preset_bvalid", 64'(bvalid), 64'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b010;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b1;
        arvalid = 1'b0; araddr = '0; arprot = 3'b001;
        rready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_bvalid",   64'(bvalid),   64'd0);
        chk("rst_rvalid",   64'(rvalid),   64'd0);
        chk("rst_awready",  64'(awready),  64'd1);
        chk("rst_wready",   64'(wready),   64'd1);
        chk("rst_arready",  64'(arready),  64'd1);
        chk("rst_rdata",    64'(rdata),    64'd0);
        chk("rst_regq",     64'(reg_q == '0), 64'd1);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        rst = 1'b0;
        tick();

        // 1: AW+W same cycle to reg 1
        awvalid = 1'b1; awaddr = 12'h004; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_awready_full", 64'(awready), 64'd0);
        chk("t1_bvalid_early", 64'(bvalid),  64'd0);
        tick();
        chk("t1_bvalid",   64'(bvalid),   64'd1);
        chk("t1_bresp",    64'(bresp),    64'd0);
        chk("t1_reg1",     64'(regv(1)),  64'hDEADBEEF);
        chk("t1_wr_pulse", 64'(wr_pulse), 64'h0002);
        tick();
        chk("t1_bvalid_clr",   64'(bvalid),   64'd0);
        chk("t1_wr_pulse_clr", 64'(wr_pulse), 64'd0);

        // 2: preset reg 2, then W first and AW three cycles later
        write_same(12'h008, 32'h11223344, 4'hF);
        wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'h1;
        tick();
        wvalid = 1'b0;
        chk("t2_wready_full", 64'(wready),  64'd0);
        chk("t2_awready",     64'(awready), 64'd1);
        tick(); tick();
        awvalid = 1'b1; awaddr = 12'h008;
        tick();
        awvalid = 1'b0;
        chk("t2_bvalid_early", 64'(bvalid), 64'd0);
        tick();
        chk("t2_bvalid",   64'(bvalid),   64'd1);
        chk("t2_bresp",    64'(bresp),    64'd0);
        chk("t2_reg2",     64'(regv(2)),  64'h112233AA);
        chk("t2_wr_pulse", 64'(wr_pulse), 64'h0004);
        tick();

        // 3: out-of-range write and read
        awvalid = 1'b1; awaddr = 12'h040; wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("t3_bvalid",   64'(bvalid),   64'd1);
        chk("t3_bresp",    64'(bresp),    64'd2);
        chk("t3_wr_pulse", 64'(wr_pulse), 64'd0);
        chk("t3_reg0",     64'(regv(0)),  64'd0);
        chk("t3_reg1",     64'(regv(1)),  64'hDEADBEEF);
        chk("t3_reg15",    64'(regv(15)), 64'd0);
        tick();
        arvalid = 1'b1; araddr = 12'h040;
        tick();
        arvalid = 1'b0;
        chk("t3_rvalid", 64'(rvalid), 64'd1);
        chk("t3_rdata",  64'(rdata),  64'd0);
        chk("t3_rresp",  64'(rresp),  64'd2);
        tick();
        chk("t3_rvalid_clr", 64'(rvalid), 64'd0);
        arvalid = 1'b1; araddr = 12'h006;
        tick();
        arvalid = 1'b0;
        chk("t3_rd1_data", 64'(rdata), 64'hDEADBEEF);
        chk("t3_rd1_resp", 64'(rresp), 64'd0);
        tick();

        // 4: BREADY backpressure with second write buffered
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 12'h00C; wvalid = 1'b1; wdata = 32'h00005555; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("t4_bvalid1", 64'(bvalid),  64'd1);
        chk("t4_bresp1",  64'(bresp),   64'd0);
        chk("t4_reg3",    64'(regv(3)), 64'h00005555);
        awvalid = 1'b1; awaddr = 12'h044; wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_awready", 64'(awready), 64'd0);
            chk("t4_hold_wready",  64'(wready),  64'd0);
            chk("t4_hold_bvalid",  64'(bvalid),  64'd1);
            chk("t4_hold_bresp",   64'(bresp),   64'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        chk("t4_bvalid2",   64'(bvalid),   64'd1);
        chk("t4_bresp2",    64'(bresp),    64'd2);
        chk("t4_wr_pulse2", 64'(wr_pulse), 64'd0);
        chk("t4_awready2",  64'(awready),  64'd1);
        tick();
        chk("t4_bvalid_clr", 64'(bvalid), 64'd0);

        // 5: read with RREADY low; same-edge write to the same register
        rready = 1'b0;
        awvalid = 1'b1; awaddr = 12'h004; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 12'h004;
        tick();
        arvalid = 1'b0;
        chk("t5_rvalid",  64'(rvalid),  64'd1);
        chk("t5_rdata",   64'(rdata),   64'hDEADBEEF);
        chk("t5_rresp",   64'(rresp),   64'd0);
        chk("t5_reg1",    64'(regv(1)), 64'hCAFEF00D);
        chk("t5_bvalid",  64'(bvalid),  64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_rvalid",  64'(rvalid),  64'd1);
            chk("t5_hold_rdata",   64'(rdata),   64'hDEADBEEF);
            chk("t5_hold_arready", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        tick();
        chk("t5_rvalid_clr", 64'(rvalid), 64'd0);
        arvalid = 1'b1; araddr = 12'h004;
        tick();
        arvalid = 1'b0;
        chk("t5_reread", 64'(rdata), 64'hCAFEF00D);
        tick();

        // 5b: zero strobe in range -> OKAY, pulse, no data change
        awvalid = 1'b1; awaddr = 12'h00C; wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("t5b_bresp",    64'(bresp),    64'd0);
        chk("t5b_reg3",     64'(regv(3)),  64'h00005555);
        chk("t5b_wr_pulse", 64'(wr_pulse), 64'h0008);
        tick();

        // 6: asynchronous reset with AW buffered and RVALID high
        rready = 1'b0;
        awvalid = 1'b1; awaddr = 12'h000;
        arvalid = 1'b1; araddr = 12'h008;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("t6_pre_awready", 64'(awready), 64'd0);
        chk("t6_pre_rvalid",  64'(rvalid),  64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_awready", 64'(awready), 64'd1);
        chk("t6_rvalid",  64'(rvalid),  64'd0);
        chk("t6_rdata",   64'(rdata),   64'd0);
        chk("t6_bvalid",  64'(bvalid),  64'd0);
        chk("t6_regq",    64'(reg_q == '0), 64'd1);
        #1 rst = 1'b0;
        rready = 1'b1;
        wvalid = 1'b1; wdata = 32'h00000001; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        chk("t6_wready", 64'(wready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_bvalid", 64'(bvalid), 64'd0);
        end
        chk("t6_reg0", 64'(regv(0)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
